stack_param: RTL

//   Parametrised synchronous LIFO stack with four commands: NOP, PUSH, POP and

---
 rtl/stack_pkg.sv | 25 ++
 rtl/stack_param_if.sv | 31 +++
 rtl/stack_mem.sv | 40 ++++
 rtl/stack_param.sv | 118 +++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and ring-pointer helpers for the parametrised LIFO stack.
// Pointers wrap modulo DEPTH, which need not be a power of two.
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  function automatic int ring_inc(input int ptr, input int depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

  function automatic int ring_dec(input int ptr, input int depth);
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

  // Slot holding entry k below the top; k is folded so the sum never goes negative.
  function automatic int ring_back(input int ptr, input int k, input int depth);
    return (ptr + depth - 1 - (k % depth)) % depth;
  endfunction

endpackage

// File: rtl/stack_param_if.sv
// Command/status bundle of the stack. The master issues commands, the
// slave (the stack itself) returns registered data and status.
interface stack_param_if
  import stack_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  cmd_e              command;
  logic [IDX_W-1:0]  index;
  logic [WIDTH-1:0]  i_data;
  logic [WIDTH-1:0]  o_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output command, index, i_data,
    input  o_data, count, full, empty, err
  );

  modport slave (
    input  command, index, i_data,
    output o_data, count, full, empty, err
  );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one
// combinational read port, synchronous active-low clear of every entry.
module stack_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!srst_n) begin
          mem_reg[gi] <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Addresses at or beyond DEPTH never occur in normal use; read zero for safety.
  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) begin
      rdata = mem_reg[raddr];
    end
  end

endmodule

// File: rtl/stack_param.sv
// Parametrised LIFO stack: NOP/PUSH/POP/GET with COUNT/FULL/EMPTY status,
// one-cycle ERR on a rejected command, and optional overwrite-oldest mode.
module stack_param
  import stack_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5,
  parameter int WRAP  = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  stack_param_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0] top_ptr_reg, top_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] o_data_reg, o_data_next;
  logic             err_reg, err_next;

  logic             we;
  logic [IDX_W-1:0] raddr;
  logic [WIDTH-1:0] rdata;
  logic             full, empty, idx_ok;
  int               depth_k;

  assign full   = (count_reg == CNT_W'(DEPTH));
  assign empty  = (count_reg == '0);
  assign idx_ok = (CNT_W'(bus.index) < count_reg);

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_mem (
    .clk    (CLK),
    .srst_n (RESET),
    .we     (we),
    .waddr  (top_ptr_reg),
    .wdata  (bus.i_data),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  // The single read port serves both POP (entry 0) and GET (entry INDEX).
  always_comb begin
    depth_k = 0;
    if (bus.command == CMD_GET) begin
      depth_k = int'(bus.index);
    end
    raddr = IDX_W'(ring_back(int'(top_ptr_reg), depth_k, DEPTH));
  end

  always_comb begin
    top_ptr_next = top_ptr_reg;
    count_next   = count_reg;
    o_data_next  = o_data_reg;
    err_next     = 1'b0;
    we           = 1'b0;
    case (bus.command)
      CMD_PUSH: begin
        if (!full) begin
          we           = 1'b1;
          top_ptr_next = IDX_W'(ring_inc(int'(top_ptr_reg), DEPTH));
          count_next   = count_reg + CNT_W'(1);
        end else if (WRAP != 0) begin
          // The next free slot on a full ring is the oldest entry.
          we           = 1'b1;
          top_ptr_next = IDX_W'(ring_inc(int'(top_ptr_reg), DEPTH));
        end else begin
          err_next = 1'b1;
        end
      end
      CMD_POP: begin
        if (!empty) begin
          o_data_next  = rdata;
          top_ptr_next = IDX_W'(ring_dec(int'(top_ptr_reg), DEPTH));
          count_next   = count_reg - CNT_W'(1);
        end else begin
          err_next = 1'b1;
        end
      end
      CMD_GET: begin
        if (idx_ok) begin
          o_data_next = rdata;
        end else begin
          o_data_next = '0;
          err_next    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      top_ptr_reg <= '0;
      count_reg   <= '0;
      o_data_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      top_ptr_reg <= top_ptr_next;
      count_reg   <= count_next;
      o_data_reg  <= o_data_next;
      err_reg     <= err_next;
    end
  end

  assign bus.o_data = o_data_reg;
  assign bus.count  = count_reg;
  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.err    = err_reg;

endmodule
